// File: rtl/fetch_sequencer.sv
// Instruction fetch and program-flow sequencer for a 14-bit PIC-style core.
// Drives the program ROM address, owns the instruction register and the circular return stack.
module fetch_sequencer #(
    parameter int                ADDR_W       = 11,
    parameter int                STACK_DEPTH  = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic [ADDR_W-1:0]              rom_addr,
    input  logic [13:0]                    rom_data,
    output logic [13:0]                    ir,
    output logic                           ir_valid,
    input  logic                           stall,
    input  logic                           skip,
    input  logic                           pcl_we,
    input  logic [7:0]                     pcl_data,
    input  logic [4:0]                     pclath,
    output logic [$clog2(STACK_DEPTH)-1:0] sp,
    output logic                           stack_ovf,
    output logic                           stack_unf
);

    localparam int              SP_W      = $clog2(STACK_DEPTH);
    localparam int              HI_W      = ADDR_W - 8;
    localparam logic [SP_W:0]   LIVE_FULL = (SP_W + 1)'(STACK_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [13:0]       ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [SP_W:0]     live_q, live_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic              is_goto, is_call, is_ret, flush;
    logic              push, pop;
    logic [SP_W-1:0]   sp_dec;
    logic              unused_bits;

    assign unused_bits = ^pclath[4:HI_W];

    // Control-flow decode only looks at real instructions, never at a flushed slot.
    always_comb begin
        is_goto = ir_valid_q && (ir_q[13:11] == 3'b101);
        is_call = ir_valid_q && (ir_q[13:11] == 3'b100);
        is_ret  = ir_valid_q && ((ir_q == 14'h0008) || (ir_q == 14'h0009) ||
                                 (ir_q[13:10] == 4'b1101));
        flush   = skip | pcl_we | is_goto | is_call | is_ret;
        // A PCL write overrides a branch in ir, so the stack must not move with it.
        push    = !stall && !pcl_we && is_call;
        pop     = !stall && !pcl_we && is_ret;
        sp_dec  = sp_q - 1'b1;
    end

    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        sp_d       = sp_q;
        live_d     = live_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        if (!stall) begin
            if (pcl_we) begin
                pc_d = {pclath[HI_W-1:0], pcl_data};
            end else if (is_goto || is_call) begin
                pc_d = ir_q[ADDR_W-1:0];
            end else if (is_ret) begin
                pc_d = stack_q[sp_dec];
            end else begin
                pc_d = pc_q + 1'b1;
            end

            if (flush) begin
                ir_d       = '0;
                ir_valid_d = 1'b0;
            end else begin
                ir_d       = rom_data;
                ir_valid_d = 1'b1;
            end

            // Live count saturates at both ends; sp keeps wrapping so the stack behaves circularly.
            if (push) begin
                sp_d = sp_q + 1'b1;
                if (live_q == LIVE_FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    live_d = live_q + 1'b1;
                end
            end
            if (pop) begin
                sp_d = sp_dec;
                if (live_q == '0) begin
                    unf_d = 1'b1;
                end else begin
                    live_d = live_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            sp_q       <= '0;
            live_q     <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            sp_q       <= sp_d;
            live_q     <= live_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Stack contents carry no reset; a CALL stores the already-incremented pc.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[sp_q] <= pc_q;
        end
    end

    assign rom_addr  = pc_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign sp        = sp_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and program-flow controller for the 14-bit PIC-style core. It drives the address of the combinational 2K×14 program ROM and registers the returned word into the instruction register for the decoder. It resolves GOTO, CALL, RETURN, RETLW and RETFIE itself using an 8-level hardware return stack, and it flushes the fetch slot on skips and PCL writes from the datapath.

## Interface
- ADDR_W, 11, program address width (ROM depth 2^ADDR_W)
- STACK_DEPTH, 8, return stack entries (power of two)
- RESET_VECTOR, 11'h000, PC value after reset

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rom_addr  out  ADDR_W  ROM address, equal to pc (combinational from pc register)
- rom_data  in  14  ROM word for rom_addr, valid in the same cycle
- ir  out  14  instruction register to decoder
- ir_valid  out  1  ir holds a real instruction (0 = flushed NOP)
- stall  in  1  hold all state this cycle
- skip  in  1  executing instruction (in ir) resolved a skip (BTFSC/BTFSS/DECFSZ/INCFSZ)
- pcl_we  in  1  datapath writes PCL this cycle
- pcl_data  in  8  new PCL value
- pclath  in  5  PCLATH register; bits [2:0] form the PC high bits on a PCL write
- sp  out  3  current stack pointer
- stack_ovf  out  1  sticky push-past-full flag
- stack_unf  out  1  sticky pop-from-empty flag

## Operation
- Two-stage pipeline: fetch (pc → rom_addr → rom_data) and execute (ir). One instruction per unstalled cycle.
- Control-flow decode on ir only when ir_valid=1:
  - GOTO ir[13:11]=3'b101
  - CALL ir[13:11]=3'b100
  - RETURN 14'h0008
  - RETFIE 14'h0009
  - RETLW ir[13:10]=4'b1101
- Branch target = ir[10:0].
- flush = skip | pcl_we | (ir_valid & control-flow).
- Next pc, by priority:
  1. pcl_we → {pclath[2:0], pcl_data}
  2. GOTO/CALL → target
  3. RETURN/RETLW/RETFIE → popped entry
  4. otherwise → pc+1, wrapping 0x7FF→0x000
- ir update:
  - flush: ir ← 14'h0000, ir_valid ← 0
  - otherwise: ir ← rom_data, ir_valid ← 1
- CALL pushes the current pc, which is the CALL address + 1: stack[sp] ← pc, then sp ← sp+1.
- Return pops: sp ← sp−1, then pc ← stack[sp−1].
- Stack is circular:
  - A push with 8 entries live overwrites the oldest entry and sets stack_ovf.
  - A pop with 0 live entries returns the wrapped entry and sets stack_unf.
  - Live count is tracked separately from sp (0..8).
  - Flags clear only on reset.
- Simultaneous events:
  - pcl_we together with control-flow in ir: pcl_we wins, and there is no push or pop.
  - skip together with control-flow: the control-flow action is taken, flushed once.
- stall=1: pc, ir, ir_valid, stack, sp and flags all hold; skip and pcl_we are ignored (the datapath must re-present them).
- RETLW W-loading and RETFIE GIE-setting are handled by the datapath; this block only redirects flow.

## Timing
- Reset (async assert, sync effect on release):
  - pc=RESET_VECTOR, so rom_addr=RESET_VECTOR
  - ir=14'h0000, ir_valid=0
  - sp=0, live count=0, stack_ovf=0, stack_unf=0
  - Stack contents are don't-care.
- Assertion mid-operation takes effect immediately, without waiting for a clock edge.
- First edge after reset release: ir=ROM[RESET_VECTOR], ir_valid=1.
- rom_addr changes only on clock edges or reset, never on inputs within a cycle.
- Control-flow cost:
  - 2 cycles, 1 flushed slot; the instruction at the target is in ir 2 edges after the branch entered ir.
  - Skip and PCL write also cost 1 flushed slot.
- skip and pcl_we are sampled on the edge ending the cycle in which ir holds the originating instruction.
- sp, stack_ovf and stack_unf update on the same edge as the push or pop.

## Test plan
- Reset and straight-line fetch:
  - rst_n low → rom_addr=0x000, ir=0, ir_valid=0
  - release with ROM[0..2]=0x01A5,0x0103,0x3001 → ir sequence 0x01A5,0x0103,0x3001 on consecutive edges
  - rst_n asserted mid-stream → outputs return to reset values with no clock edge
- GOTO: 0x2804 at 0x012 → next edge ir=0x0000/ir_valid=0 and rom_addr=0x004; following edge ir=ROM[0x004], ir_valid=1.
- CALL/RETURN:
  - 0x2100 at 0x005 → rom_addr=0x100, sp=1, stack[0]=0x006
  - 0x0008 at 0x100 → rom_addr=0x006, sp=0, no flags
- Skip: skip=1 while ir=0x0BA2 from 0x00B → word at 0x00C discarded (ir=0, ir_valid=0), then ir=ROM[0x00D].
- Stack limits:
  - 9 nested CALLs → stack_ovf=1, sp=1; 8 RETURNs then recover addresses of CALLs 9..2
  - a 9th RETURN → stack_unf=1
  - both flags stay set until rst_n
- Stall and PCL write:
  - stall=1 for 3 cycles → rom_addr and ir unchanged, skip pulse ignored
  - pcl_we=1, pcl_data=0x34, pclath=5'h03 → rom_addr=0x334, 1 flushed slot
